// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the bit-serial ALU operand link.
package alu_pkg;

    localparam int ALU_WORD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit-counter width for a word of the given size; never below one bit.
    function automatic int SER_CNT_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Beat counter for serial framing: clears on load, counts beats, flags position WIDTH-1.
module serial_bit_counter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WORD_W,
    localparam int CNT_W = SER_CNT_W(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign term_o = (cnt_q == CNT_W'(WIDTH - 1));
    assign cnt_o  = cnt_q;

    // Clear wins over increment; the count saturates at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !term_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out operand transmitter with first/last framing and backpressure.
module piso_serializer
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WORD_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             SER_READY,
    output logic             SER_VALID,
    output logic             SER_OUT,
    output logic             SER_FIRST,
    output logic             SER_LAST,
    output logic             BUSY
);

    localparam int CNT_W = SER_CNT_W(WIDTH);

    ser_state_t       state_q;
    ser_state_t       state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CNT_W-1:0] cnt;
    logic             cnt_term;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             ready_raw;

    serial_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .CLK    (CLK),
        .RST    (RST),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt),
        .term_o (cnt_term)
    );

    assign shreg_shifted = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                     : {shreg_q[WIDTH-2:0], 1'b0};

    // Handshakes: a transfer happens on a rising edge where both valid and ready
    // are high. Load side ready is combinational; serial side valid is a flop and
    // holds, with its data, until the downstream takes it.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        ready_raw = 1'b0;
        case (state_q)
            IDLE: begin
                ready_raw = 1'b1;
                if (LOAD_VALID) begin
                    shreg_d = LOAD_DATA;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (SER_READY) begin
                    if (!cnt_term) begin
                        shreg_d = shreg_shifted;
                        cnt_inc = 1'b1;
                    end else begin
                        ready_raw = 1'b1;
                        cnt_clr   = 1'b1;
                        if (LOAD_VALID) begin
                            shreg_d = LOAD_DATA;
                        end else begin
                            shreg_d = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                shreg_d = '0;
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    // The shift register is zero whenever IDLE, so SER_OUT needs no state gating.
    assign LOAD_READY = ready_raw & ~RST;
    assign BUSY       = (state_q == SHIFT);
    assign SER_VALID  = BUSY;
    assign SER_OUT    = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    assign SER_FIRST  = BUSY & (cnt == '0);
    assign SER_LAST   = BUSY & cnt_term;

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed bench for piso_serializer, LSB-first and MSB-first instances side by side.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         ser_ready;

    logic lr_l, sv_l, so_l, sf_l, sl_l, bz_l;
    logic lr_m, sv_m, so_m, sf_m, sl_m, bz_m;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the word in flight and how many of its bits remain.
    logic [W-1:0] word;
    int           left;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] acc_l;
    logic [W-1:0] acc_m;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .CLK        (clk),
        .RST        (rst),
        .LOAD_VALID (load_valid),
        .LOAD_READY (lr_l),
        .LOAD_DATA  (load_data),
        .SER_READY  (ser_ready),
        .SER_VALID  (sv_l),
        .SER_OUT    (so_l),
        .SER_FIRST  (sf_l),
        .SER_LAST   (sl_l),
        .BUSY       (bz_l)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .CLK        (clk),
        .RST        (rst),
        .LOAD_VALID (load_valid),
        .LOAD_READY (lr_m),
        .LOAD_DATA  (load_data),
        .SER_READY  (ser_ready),
        .SER_VALID  (sv_m),
        .SER_OUT    (so_m),
        .SER_FIRST  (sf_m),
        .SER_LAST   (sl_m),
        .BUSY       (bz_m)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lr_l"}, 8'(lr_l), 8'd0);
        check({tag, "_sv_l"}, 8'(sv_l), 8'd0);
        check({tag, "_so_l"}, 8'(so_l), 8'd0);
        check({tag, "_sf_l"}, 8'(sf_l), 8'd0);
        check({tag, "_sl_l"}, 8'(sl_l), 8'd0);
        check({tag, "_bz_l"}, 8'(bz_l), 8'd0);
        check({tag, "_lr_m"}, 8'(lr_m), 8'd0);
        check({tag, "_sv_m"}, 8'(sv_m), 8'd0);
        check({tag, "_so_m"}, 8'(so_m), 8'd0);
        check({tag, "_bz_m"}, 8'(bz_m), 8'd0);
    endtask

    // One clock cycle: apply inputs, compare against the model, then advance both.
    task automatic step(input logic lv, input logic [W-1:0] ld, input logic sr);
        logic e_valid, e_first, e_last, e_lsb, e_msb, e_ready, beat, accept;
        logic [W-1:0] e_word;
        load_valid = lv;
        load_data  = ld;
        ser_ready  = sr;
        #1;
        e_valid = (left != 0);
        e_first = (left == W);
        e_last  = (left == 1);
        e_lsb   = e_valid ? word[W-left] : 1'b0;
        e_msb   = e_valid ? word[left-1] : 1'b0;
        e_ready = !rst && (left == 0 || (left == 1 && sr));
        check("load_ready_l", 8'(lr_l), 8'(e_ready));
        check("load_ready_m", 8'(lr_m), 8'(e_ready));
        check("ser_valid_l",  8'(sv_l), 8'(e_valid));
        check("ser_valid_m",  8'(sv_m), 8'(e_valid));
        check("busy_l",       8'(bz_l), 8'(e_valid));
        check("ser_out_l",    8'(so_l), 8'(e_lsb));
        check("ser_out_m",    8'(so_m), 8'(e_msb));
        check("ser_first_l",  8'(sf_l), 8'(e_first));
        check("ser_first_m",  8'(sf_m), 8'(e_first));
        check("ser_last_l",   8'(sl_l), 8'(e_last));
        check("ser_last_m",   8'(sl_m), 8'(e_last));
        beat   = e_valid && sr;
        accept = lv && e_ready;
        if (beat) begin
            acc_l[W-left] = so_l;
            acc_m = {acc_m[W-2:0], so_m};
            if (left == 1) begin
                check("sb_depth", 8'(exp_q.size()), 8'd1);
                if (exp_q.size() != 0) begin
                    e_word = exp_q.pop_front();
                    check("sb_word_l", acc_l, e_word);
                    check("sb_word_m", acc_m, e_word);
                end
            end
            left--;
        end
        if (accept) begin
            word = ld;
            left = W;
            exp_q.push_back(ld);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; the frame in flight is dropped from the scoreboard.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        if (left != 0) begin
            void'(exp_q.pop_back());
            left = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_held");
        rst = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input int idle_after);
        step(1'b1, d, 1'b1);
        repeat (W + idle_after) step(1'b0, '0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        ser_ready  = 1'b0;
        word       = '0;
        left       = 0;
        acc_l      = '0;
        acc_m      = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single word, no backpressure; MSB instance covers the mirrored order.
        send(8'hA5, 1);

        // Backpressure after beat 2.
        step(1'b1, 8'h0F, 1'b1);
        repeat (2) step(1'b0, '0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0);
        repeat (7) step(1'b0, '0, 1'b1);

        // Back-to-back words with LOAD_VALID held high.
        step(1'b1, 8'h3C, 1'b1);
        repeat (W) step(1'b1, 8'hC3, 1'b1);
        repeat (W + 1) step(1'b0, '0, 1'b1);

        send(8'h01, 1);

        // Load attempts while busy must not disturb the word in flight.
        step(1'b1, 8'h00, 1'b1);
        repeat (6) step(1'b1, 8'hFF, 1'b1);
        step(1'b0, 8'hFF, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        repeat (W + 1) step(1'b0, '0, 1'b1);

        // Abort after beat 3, then a clean word.
        step(1'b1, 8'hAA, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        mid_reset();
        send(8'h55, 1);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                mid_reset();
            end
            step(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));
        end

        repeat (W + 4) step(1'b0, '0, 1'b1);
        check("sb_drain", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
